// File: rtl/id_ctrl_stage_pkg.sv
// Shared decode definitions for the ID control stage: opcodes,
// ALU op codes and the control bundle carried across ID/EX.
package id_ctrl_stage_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_SLL  = 4'd2;
    localparam logic [3:0] ALU_SRL  = 4'd3;
    localparam logic [3:0] ALU_SLT  = 4'd4;
    localparam logic [3:0] ALU_SRA  = 4'd5;
    localparam logic [3:0] ALU_AND  = 4'd6;
    localparam logic [3:0] ALU_OR   = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;
    localparam logic [3:0] ALU_MUL  = 4'd10;

    typedef struct packed {
        logic [3:0] aluop;
        logic       alusrc;
        logic       regwrite;
        logic       memwrite;
        logic       memread;
        logic       memtoreg;
        logic       branch;
        logic       jump;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/id_ctrl_if.sv
// Handshake/bus bundle between IF/ID, the ID control stage and EX.
// slave = the stage; master = upstream/downstream driver side.
interface id_ctrl_if #(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter int CNT_W   = 16
);
    logic               in_valid;
    logic               in_ready;
    logic [31:0]        instr;
    logic [XLEN-1:0]    pc;
    logic               flush;
    logic               out_valid;
    logic               out_ready;
    logic [XLEN-1:0]    out_pc;
    logic [XLEN-1:0]    out_imm;
    logic [ALUOP_W-1:0] out_aluop;
    logic               out_alusrc;
    logic               out_regwrite;
    logic               out_memwrite;
    logic               out_memread;
    logic               out_memtoreg;
    logic               out_branch;
    logic               out_jump;
    logic [4:0]         out_rs1;
    logic [4:0]         out_rs2;
    logic [4:0]         out_rd;
    logic               out_illegal;
    logic               hazard_stall;
    logic [CNT_W-1:0]   stall_cnt;

    modport slave (
        input  in_valid, instr, pc, flush, out_ready,
        output in_ready, out_valid, out_pc, out_imm, out_aluop,
        output out_alusrc, out_regwrite, out_memwrite, out_memread,
        output out_memtoreg, out_branch, out_jump,
        output out_rs1, out_rs2, out_rd, out_illegal,
        output hazard_stall, stall_cnt
    );

    modport master (
        output in_valid, instr, pc, flush, out_ready,
        input  in_ready, out_valid, out_pc, out_imm, out_aluop,
        input  out_alusrc, out_regwrite, out_memwrite, out_memread,
        input  out_memtoreg, out_branch, out_jump,
        input  out_rs1, out_rs2, out_rd, out_illegal,
        input  hazard_stall, stall_cnt
    );
endinterface

// File: rtl/id_ctrl_stage_ctrl_decode.sv
// Combinational RV32 decoder: instr -> control bundle, sign-extended
// immediate and source-register usage flags.
module ctrl_decode
    import id_ctrl_stage_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter bit EN_MUL = 1'b0
) (
    input  logic [31:0]     instr,
    output ctrl_t           ctrl,
    output logic [XLEN-1:0] imm,
    output logic            uses_rs1,
    output logic            uses_rs2
);
    logic [6:0]  op;
    logic [6:0]  f7;
    logic [2:0]  f3;
    logic [31:0] imm_i, imm_s, imm_b, imm_j, imm_u, imm32;
    logic [3:0]  r_op, i_op;
    logic        r_ok, i_ok, ld_ok, st_ok, br_ok;

    assign op = instr[6:0];
    assign f3 = instr[14:12];
    assign f7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7],
                    instr[30:25], instr[11:8], 1'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12],
                    instr[20], instr[30:21], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};

    assign ld_ok = (f3 != 3'd3) && (f3 <= 3'd5);
    assign st_ok = (f3 <= 3'd2);
    assign br_ok = (f3[2:1] != 2'b01);

    always_comb begin
        r_op = ALU_ADD;
        r_ok = 1'b1;
        unique case ({f7, f3})
            {7'h00, 3'd0}: r_op = ALU_ADD;
            {7'h20, 3'd0}: r_op = ALU_SUB;
            {7'h00, 3'd1}: r_op = ALU_SLL;
            {7'h00, 3'd2}: r_op = ALU_SLT;
            {7'h00, 3'd3}: r_op = ALU_SLTU;
            {7'h00, 3'd4}: r_op = ALU_XOR;
            {7'h00, 3'd5}: r_op = ALU_SRL;
            {7'h20, 3'd5}: r_op = ALU_SRA;
            {7'h00, 3'd6}: r_op = ALU_OR;
            {7'h00, 3'd7}: r_op = ALU_AND;
            {7'h01, 3'd0}: begin
                r_op = ALU_MUL;
                r_ok = EN_MUL;
            end
            default: r_ok = 1'b0;
        endcase
    end

    // Shift-immediates carry funct7 in imm[11:5]; all others ignore it.
    always_comb begin
        i_op = ALU_ADD;
        i_ok = 1'b1;
        unique case (f3)
            3'd0: i_op = ALU_ADD;
            3'd1: begin
                i_op = ALU_SLL;
                i_ok = (f7 == 7'h00);
            end
            3'd2: i_op = ALU_SLT;
            3'd3: i_op = ALU_SLTU;
            3'd4: i_op = ALU_XOR;
            3'd5: begin
                i_op = f7[5] ? ALU_SRA : ALU_SRL;
                i_ok = (f7 == 7'h00) || (f7 == 7'h20);
            end
            3'd6: i_op = ALU_OR;
            3'd7: i_op = ALU_AND;
        endcase
    end

    always_comb begin
        ctrl     = '0;
        imm32    = '0;
        uses_rs1 = 1'b0;
        uses_rs2 = 1'b0;
        unique case (1'b1)
            op == OP_R: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (r_ok) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.aluop    = r_op;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            op == OP_LOAD: begin
                uses_rs1 = 1'b1;
                if (ld_ok) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.memread  = 1'b1;
                    ctrl.memtoreg = 1'b1;
                    imm32         = imm_i;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            op == OP_IMM: begin
                uses_rs1 = 1'b1;
                if (i_ok) begin
                    ctrl.regwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    ctrl.aluop    = i_op;
                    imm32         = imm_i;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            op == OP_STORE: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (st_ok) begin
                    ctrl.memwrite = 1'b1;
                    ctrl.alusrc   = 1'b1;
                    imm32         = imm_s;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            op == OP_BRANCH: begin
                uses_rs1 = 1'b1;
                uses_rs2 = 1'b1;
                if (br_ok) begin
                    ctrl.branch = 1'b1;
                    ctrl.aluop  = ALU_SUB;
                    imm32       = imm_b;
                end else begin
                    ctrl.illegal = 1'b1;
                end
            end
            op == OP_JAL: begin
                ctrl.jump     = 1'b1;
                ctrl.regwrite = 1'b1;
                imm32         = imm_j;
            end
            op == OP_LUI: begin
                ctrl.regwrite = 1'b1;
                ctrl.alusrc   = 1'b1;
                imm32         = imm_u;
            end
            op == OP_SYSTEM: ;
            default: ctrl.illegal = 1'b1;
        endcase
    end

    assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/id_ctrl_stage.sv
// ID/EX control stage: decode, load-use bubble insertion, flush,
// valid/ready handshake and saturating stall counter. Ports: clk, rst_n, bus.
module id_ctrl_stage
    import id_ctrl_stage_pkg::*;
#(
    parameter int XLEN    = 32,
    parameter int ALUOP_W = 4,
    parameter bit EN_MUL  = 1'b0,
    parameter int CNT_W   = 16
) (
    input  logic      clk,
    input  logic      rst_n,
    id_ctrl_if.slave  bus
);
    ctrl_t            dec;
    logic [XLEN-1:0]  dec_imm;
    logic             uses_rs1, uses_rs2;
    logic [4:0]       rs1, rs2, rd;

    ctrl_t            q;
    logic             vq;
    logic [XLEN-1:0]  pc_q, imm_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [CNT_W-1:0] cnt_q;

    logic adv, hazard, clr;

    ctrl_decode #(
        .XLEN   (XLEN),
        .EN_MUL (EN_MUL)
    ) u_dec (
        .instr    (bus.instr),
        .ctrl     (dec),
        .imm      (dec_imm),
        .uses_rs1 (uses_rs1),
        .uses_rs2 (uses_rs2)
    );

    assign rs1 = bus.instr[19:15];
    assign rs2 = bus.instr[24:20];
    assign rd  = bus.instr[11:7];

    assign adv = !vq || bus.out_ready;

    // Held load whose destination the incoming instruction reads.
    assign hazard = rst_n && bus.in_valid && vq && q.memread
                 && (rd_q != 5'd0)
                 && ((uses_rs1 && (rs1 == rd_q))
                  || (uses_rs2 && (rs2 == rd_q)));

    assign bus.in_ready     = rst_n && adv && !hazard && !bus.flush;
    assign bus.hazard_stall = rst_n && adv && hazard && !bus.flush;

    // Reset, flush and bubble all leave an empty, zeroed entry.
    assign clr = !rst_n || bus.flush || (adv && hazard);

    always_ff @(posedge clk) begin
        if (clr) begin
            vq    <= 1'b0;
            q     <= '0;
            pc_q  <= '0;
            imm_q <= '0;
            rs1_q <= '0;
            rs2_q <= '0;
            rd_q  <= '0;
        end else if (adv) begin
            vq    <= bus.in_valid;
            q     <= dec;
            pc_q  <= bus.pc;
            imm_q <= dec_imm;
            rs1_q <= rs1;
            rs2_q <= rs2;
            rd_q  <= rd;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (bus.hazard_stall && !(&cnt_q)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.out_valid    = vq;
    assign bus.out_pc       = pc_q;
    assign bus.out_imm      = imm_q;
    assign bus.out_aluop    = ALUOP_W'(q.aluop);
    assign bus.out_alusrc   = q.alusrc;
    assign bus.out_regwrite = q.regwrite;
    assign bus.out_memwrite = q.memwrite;
    assign bus.out_memread  = q.memread;
    assign bus.out_memtoreg = q.memtoreg;
    assign bus.out_branch   = q.branch;
    assign bus.out_jump     = q.jump;
    assign bus.out_rs1      = rs1_q;
    assign bus.out_rs2      = rs2_q;
    assign bus.out_rd       = rd_q;
    assign bus.out_illegal  = q.illegal;
    assign bus.stall_cnt    = cnt_q;

endmodule
